// File: rtl/mp_register_file_pkg.sv
// Shared defaults for the MIPS register file and the stages that use it.
// Also the index of the hardwired zero register.
package mp_register_file_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NREAD  = 2;
    localparam int DEF_PEND_W = 2;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/mp_register_file_scoreboard.sv
// Per-register pending-write counters, incremented at issue and decremented at writeback.
// Provides IssueRdy and a pending-count lookup for each read port.
module mp_register_file_scoreboard
    import mp_register_file_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NREAD  = DEF_NREAD,
    parameter int PEND_W = DEF_PEND_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Issue,
    input  logic [ADDR_W-1:0]         IssueRW,
    input  logic                      RegWr,
    input  logic [ADDR_W-1:0]         RW,
    input  logic [NREAD*ADDR_W-1:0]   RA,
    output logic [NREAD*PEND_W-1:0]   PendRd,
    output logic                      IssueRdy
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend [DEPTH];
    logic [DEPTH-1:0]  inc;
    logic [DEPTH-1:0]  dec;

    assign IssueRdy = (pend[IssueRW] != PEND_MAX);

    // Entry 0 can never increment, so it stays at zero without special casing.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inc[i] = Issue && IssueRdy
                  && (IssueRW != ADDR_W'(ZERO_REG))
                  && (IssueRW == ADDR_W'(i));
            dec[i] = RegWr && (RW == ADDR_W'(i))
                  && (pend[i] != '0);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (inc[i] && !dec[i]) begin
                    pend[i] <= pend[i] + 1'b1;
                end else if (dec[i] && !inc[i]) begin
                    pend[i] <= pend[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        PendRd = '0;
        for (int k = 0; k < NREAD; k++) begin
            PendRd[k*PEND_W +: PEND_W] = pend[RA[k*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/mp_register_file.sv
// Multi-read-port register file with write-through bypass and pending-write stalls.
// Register 0 reads as zero and ignores writes.
module mp_register_file
    import mp_register_file_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NREAD  = DEF_NREAD,
    parameter int PEND_W = DEF_PEND_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NREAD*ADDR_W-1:0]  RA,
    output logic [NREAD*WIDTH-1:0]   BusR,
    output logic [NREAD-1:0]         Stall,
    input  logic [ADDR_W-1:0]        RW,
    input  logic [WIDTH-1:0]         BusW,
    input  logic                     RegWr,
    input  logic                     Issue,
    input  logic [ADDR_W-1:0]        IssueRW,
    output logic                     IssueRdy
);

    logic [WIDTH-1:0]        rf [DEPTH];
    logic [NREAD*PEND_W-1:0] pendRd;
    logic                    wrEn;

    // Reset must also kill the combinational bypass path.
    assign wrEn = RegWr && !Rst;

    mp_register_file_scoreboard #(
        .DEPTH  (DEPTH),
        .NREAD  (NREAD),
        .PEND_W (PEND_W),
        .ADDR_W (ADDR_W)
    ) uScoreboard (
        .Clk      (Clk),
        .Rst      (Rst),
        .Issue    (Issue),
        .IssueRW  (IssueRW),
        .RegWr    (wrEn),
        .RW       (RW),
        .RA       (RA),
        .PendRd   (pendRd),
        .IssueRdy (IssueRdy)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (RegWr && (RW != ADDR_W'(ZERO_REG))) begin
            rf[RW] <= BusW;
        end
    end

    logic [ADDR_W-1:0] ra;
    logic [PEND_W-1:0] pk;
    logic              hit;

    always_comb begin
        BusR  = '0;
        Stall = '0;
        ra    = '0;
        pk    = '0;
        hit   = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            ra  = RA[k*ADDR_W +: ADDR_W];
            pk  = pendRd[k*PEND_W +: PEND_W];
            hit = wrEn && (RW == ra);
            if (ra != ADDR_W'(ZERO_REG)) begin
                BusR[k*WIDTH +: WIDTH] = hit ? BusW : rf[ra];
                // The write being bypassed this cycle satisfies one pending count.
                Stall[k] = (pk > PEND_W'(hit));
            end
        end
    end

endmodule

// File: doc/mp_register_file.md
# mp_register_file

Parametrised multi-read-port register file for the pipelined MIPS datapath, with a write-through bypass and a per-register pending-write scoreboard. Decode reads operands and gets per-port stall indications. Issue marks destinations pending, and writeback retires them. Register 0 is hardwired to zero. This block replaces the fixed 2-read/1-write, 32x32 register file.

## Interface
Parameters:
- WIDTH, 32, data width of every register
- DEPTH, 32, number of registers; power of two, at least 2; ADDR_W = log2(DEPTH)
- NREAD, 2, number of read ports, 1 to 4
- PEND_W, 2, width of each pending counter; maximum in-flight writes per register is PEND_MAX = 2^PEND_W - 1

Ports:
- Clk, in, 1, single clock; all state updates on the rising edge
- Rst, in, 1, reset, asynchronous, active-high
- RA, in, NREAD*ADDR_W, read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- BusR, out, NREAD*WIDTH, read data; port k occupies bits [k*WIDTH +: WIDTH]
- Stall, out, NREAD, Stall[k] high means the operand on port k is not yet valid
- RW, in, ADDR_W, writeback address
- BusW, in, WIDTH, writeback data
- RegWr, in, 1, writeback enable
- Issue, in, 1, an instruction writing IssueRW is issued this cycle
- IssueRW, in, ADDR_W, destination of the issuing instruction
- IssueRdy, out, 1, pend[IssueRW] != PEND_MAX

## Operation
- Storage: DEPTH x WIDTH registers and one PEND_W-bit counter pend[i] per register.
- Write: when RegWr is high and RW != 0, RF[RW] <= BusW on the rising edge. Writes to RW = 0 are discarded.
- Read port k, combinational:
  - If RA_k == 0, BusR_k = 0.
  - Else if RegWr is high and RW == RA_k, BusR_k = BusW (bypass).
  - Else BusR_k = RF[RA_k].
- Scoreboard inputs:
  - inc = Issue && IssueRdy && IssueRW != 0 && IssueRW == i
  - dec = RegWr && RW == i && pend[i] != 0
  - pend[i] updates by +1 on inc only, -1 on dec only, and holds when both or neither are true.
- Issue while IssueRdy is low is ignored: no counter change. Stalling the front end is the decode stage's job.
- Writeback to a register with pend = 0 still writes data. The counter saturates at 0; there is no underflow.
- pend[0] is constantly 0.
- Stall_k = (RA_k != 0) && (pend[RA_k] > bypass_hit_k), where bypass_hit_k = 1 if RegWr && RW == RA_k, else 0. A read satisfied by the last outstanding write through the bypass does not stall.
- Stall is computed from pre-edge counter values. A same-cycle Issue to RA_k does not raise Stall_k until the next cycle.

## Timing
- Reads, Stall and IssueRdy are combinational from the current state and inputs; read latency is 0 cycles.
- Writes and counter updates take effect at the next rising edge of Clk.
- Reset, asynchronous, with Rst high:
  - All RF entries are 0 and all pend counters are 0 immediately.
  - RegWr and Issue are ignored and the bypass is disabled.
  - BusR = 0, Stall = 0, IssueRdy = 1.
- Reset asserted mid-operation discards every pending count and all register contents. Normal operation resumes at the first rising edge after Rst falls.
- Simultaneous issue and writeback to the same register: the counter is unchanged and the data is written.
- Multiple read ports addressing the same register receive identical data and identical Stall.

## Structure
- A shared header defines the default WIDTH, DEPTH, NREAD and PEND_W and the zero-register index. Every pipeline stage includes it.
- The natural sub-module is regfile_scoreboard. It holds the pend counter array, the increment/decrement logic, IssueRdy, and a per-port pending-count lookup.
- The top level holds the storage array, the write logic, the bypass muxes and the final Stall compare.

## Test plan
- Reset: hold Rst high with RegWr high, RW = 5, BusW = 0xDEADBEEF. Required: BusR = 0 on all ports and RF[5] = 0 after Rst falls. Then assert Rst mid-run with pend[3] = 2. Required: pend[3] = 0 and Stall = 0 immediately.
- Write/read and zero register:
  - Write 0x12345678 to r7, then read r7 on ports 0 and 1. Required: both return 0x12345678.
  - Write 0xFFFFFFFF to r0. Required: a read of r0 returns 0.
- Bypass: RegWr with RW = 9, BusW = 0xA5A5A5A5, and RA_0 = 9 in the same cycle. Required: BusR_0 = 0xA5A5A5A5 before the edge.
- Scoreboard:
  - Issue r4 twice. Required: Stall_0 = 1 with RA_0 = 4.
  - Writeback r4 once. Required: Stall_0 stays 1 in that cycle (pend 2 > hit 1).
  - Second writeback. Required: Stall_0 = 0 in that cycle through the bypass, and pend[4] = 0 afterwards.
- Saturation: issue r6 until pend = 3. Required: IssueRdy = 0, and a further Issue leaves pend at 3. Writeback with pend = 0 leaves pend at 0 and updates the data.
- Simultaneous events: Issue r2 and writeback r2 in one cycle starting at pend = 1. Required: pend stays 1 and RF[2] = BusW.
